// File: rtl/vx_warp_ibuffer.sv
// rtl/vx_warp_ibuffer.sv - per-warp instruction FIFOs with round-robin issue selection
// Grants lock onto the presented warp while issue stalls so out_wis/out_data stay stable.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64,
  localparam int WW       = $clog2(NUM_WARPS),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WW-1:0]        in_wis,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WW-1:0]        out_wis,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] full_mask,
  output logic [NUM_WARPS-1:0] empty_mask
);

  localparam int PW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATAW-1:0] mem [NUM_WARPS][DEPTH];
  logic [PW-1:0]    rd_ptr [NUM_WARPS];
  logic [PW-1:0]    wr_ptr [NUM_WARPS];
  logic [CW-1:0]    count  [NUM_WARPS];

  logic [WW-1:0]        rr;
  logic                 locked;
  logic [WW-1:0]        lock_wis;
  logic [WW-1:0]        scan_wis;
  logic [WW-1:0]        scan_idx;
  logic                 scan_found;
  logic [WW-1:0]        grant_wis;
  logic                 enq;
  logic                 deq;
  logic [NUM_WARPS-1:0] enq_vec;
  logic [NUM_WARPS-1:0] deq_vec;

  always_comb begin
    full_mask  = '0;
    empty_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      full_mask[w]  = (count[w] == DEPTH_C);
      empty_mask[w] = (count[w] == '0);
    end
  end

  assign in_ready  = !full_mask[in_wis];
  assign out_valid = !(&empty_mask);

  // First non-empty warp at or after rr, wrapping modulo NUM_WARPS.
  always_comb begin
    scan_wis   = rr;
    scan_idx   = rr;
    scan_found = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr + WW'(i);
      if (!scan_found && !empty_mask[scan_idx]) begin
        scan_wis   = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  assign grant_wis = locked ? lock_wis : scan_wis;
  assign out_wis   = grant_wis;
  assign out_data  = mem[grant_wis][rd_ptr[grant_wis]];

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_comb begin
    enq_vec = '0;
    deq_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      enq_vec[w] = enq && (in_wis == WW'(w));
      deq_vec[w] = deq && (grant_wis == WW'(w));
    end
  end

  // Payload storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem[in_wis][wr_ptr[in_wis]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
        count[w]  <= '0;
      end
      rr       <= '0;
      locked   <= 1'b0;
      lock_wis <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (enq_vec[w]) wr_ptr[w] <= wr_ptr[w] + 1'b1;
        if (deq_vec[w]) rd_ptr[w] <= rd_ptr[w] + 1'b1;
        if (enq_vec[w] && !deq_vec[w]) count[w] <= count[w] + 1'b1;
        else if (!enq_vec[w] && deq_vec[w]) count[w] <= count[w] - 1'b1;
      end
      if (deq) begin
        rr     <= grant_wis + 1'b1;
        locked <= 1'b0;
      end else if (out_valid) begin
        locked   <= 1'b1;
        lock_wis <= grant_wis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        assert (count[w] <= DEPTH_C);
        assert (!(deq_vec[w] && count[w] == '0));
        assert (!(enq_vec[w] && !deq_vec[w] && count[w] == DEPTH_C));
      end
    end
  end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// tb/tb_vx_warp_ibuffer.sv - directed scoreboard bench for vx_warp_ibuffer
module tb_vx_warp_ibuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_wis;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_wis;
  logic [63:0] out_data;
  logic        out_ready;
  logic [3:0]  full_mask;
  logic [3:0]  empty_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb [4][$];
  int          mcount [4];
  int          exp_wis [$];

  vx_warp_ibuffer #(.NUM_WARPS(4), .DEPTH(4), .DATAW(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_wis(in_wis), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_wis(out_wis), .out_data(out_data), .out_ready(out_ready),
    .full_mask(full_mask), .empty_mask(empty_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int w, input logic [63:0] d);
    in_valid = 1'b1;
    in_wis   = 2'(w);
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 50) begin
      step();
      n++;
    end
    check("drain_bound", 64'(n < 50), 64'd1);
  endtask

  // Reference model: per-warp counts and data queues, updated at each negedge.
  always @(negedge clk) begin
    logic [3:0] ef, ee;
    logic       ev, er;
    int         ow, iw;
    if (reset) begin
      for (int w = 0; w < 4; w++) begin
        sb[w].delete();
        mcount[w] = 0;
      end
      exp_wis.delete();
    end else begin
      ev = 1'b0;
      for (int w = 0; w < 4; w++) begin
        ef[w] = (mcount[w] == 4);
        ee[w] = (mcount[w] == 0);
        if (mcount[w] != 0) ev = 1'b1;
      end
      check("full_mask", 64'(full_mask), 64'(ef));
      check("empty_mask", 64'(empty_mask), 64'(ee));
      check("out_valid", 64'(out_valid), 64'(ev));
      iw = int'(in_wis);
      er = (mcount[iw] != 4);
      if (in_valid) check("in_ready", 64'(in_ready), 64'(er));
      if (ev && out_valid && out_ready) begin
        ow = int'(out_wis);
        if (exp_wis.size() > 0) check("out_wis_order", 64'(out_wis), 64'(exp_wis.pop_front()));
        check("pop_nonempty", 64'(sb[ow].size() > 0), 64'd1);
        if (sb[ow].size() > 0) begin
          check("out_data", out_data, sb[ow].pop_front());
          mcount[ow]--;
        end
      end
      if (in_valid && er) begin
        sb[iw].push_back(in_data);
        mcount[iw]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_wis = 2'd0; in_data = 64'd0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_full", 64'(full_mask), 64'h0);
    check("rst_empty", 64'(empty_mask), 64'hF);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single entry, no empty bypass
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_wis = 2'd2; in_data = 64'hA5;
    exp_wis.push_back(2);
    #3 check("nobypass_valid", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    #3;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_wis", 64'(out_wis), 64'd2);
    check("single_data", out_data, 64'hA5);
    step();
    #3 check("single_empty", 64'(empty_mask), 64'hF);

    // Fill warp 1, then drain in order
    step();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) enq(1, 64'(i));
    #3;
    check("fill_full", 64'(full_mask), 64'h2);
    in_wis = 2'd1;
    #0 check("fill_ready_w1", 64'(in_ready), 64'd0);
    in_wis = 2'd0;
    #1 check("fill_ready_w0", 64'(in_ready), 64'd1);
    step();
    repeat (4) exp_wis.push_back(1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_wis = 2'd1; in_data = 64'h99;
    #3 check("nofullbypass", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    drain();

    // Round robin from rr = 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    enq(0, 64'h10); enq(0, 64'h11); enq(1, 64'h12);
    enq(1, 64'h13); enq(3, 64'h14); enq(3, 64'h15);
    exp_wis.push_back(0); exp_wis.push_back(1); exp_wis.push_back(3);
    exp_wis.push_back(0); exp_wis.push_back(1); exp_wis.push_back(3);
    out_ready = 1'b1;
    drain();
    check("rr_all_seen", 64'(exp_wis.size()), 64'd0);

    // Stall lock on warp 3 while warp 0 arrives
    out_ready = 1'b0;
    enq(3, 64'h30);
    #3 check("lock_wis_a", 64'(out_wis), 64'd3);
    step();
    enq(0, 64'h31);
    #3;
    check("lock_wis_b", 64'(out_wis), 64'd3);
    check("lock_data_b", out_data, 64'h30);
    step();
    #3 check("lock_wis_c", 64'(out_wis), 64'd3);
    step();
    exp_wis.push_back(3); exp_wis.push_back(0);
    out_ready = 1'b1;
    #3 check("lock_fire_wis", 64'(out_wis), 64'd3);
    step();
    #3 check("after_fire_wis", 64'(out_wis), 64'd0);
    step();
    drain();

    // Simultaneous enqueue/dequeue on warp 0 at count 2
    out_ready = 1'b0;
    enq(0, 64'h40); enq(0, 64'h41);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_wis = 2'd0; in_data = 64'h50 + 64'(k);
      out_ready = 1'b1;
      #3 check("wrap_count", 64'(dut.count[0]), 64'd2);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset with three queued entries
    out_ready = 1'b0;
    enq(0, 64'h60); enq(1, 64'h61); enq(2, 64'h62);
    reset = 1'b1;
    in_valid = 1'b1; in_wis = 2'd3; in_data = 64'h77;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    #3;
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_empty", 64'(empty_mask), 64'hF);
    check("rst2_full", 64'(full_mask), 64'h0);
    check("rst2_rr", 64'(dut.rr), 64'd0);
    step();
    check("end_exp_wis", 64'(exp_wis.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
